conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder_if.sv | 22 ++
 rtl/conv_encoder.sv | 93 +++++++++
 2 files changed

// File: rtl/conv_encoder_if.sv
// Frame handshake and symbol stream between a frame source and the
// rate-1/2 convolutional encoder.
interface conv_encoder_if #(
  parameter int SIZE_DATA_IN = 8
);
  logic                    i_start;
  logic [SIZE_DATA_IN-1:0] i_data;
  logic                    o_ready;
  logic [1:0]              o_symbol;
  logic                    o_valid;
  logic                    o_done;

  modport master (
    output i_start, i_data,
    input  o_ready, o_symbol, o_valid, o_done
  );

  modport slave (
    input  i_start, i_data,
    output o_ready, o_symbol, o_valid, o_done
  );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 feed-forward convolutional encoder. Encodes one message word
// MSB first, flushes with two zero tail bits, then pulses o_done.
module conv_encoder #(
  parameter int       SIZE_DATA_IN = 8,
  parameter bit [2:0] G0           = 3'b111,
  parameter bit [2:0] G1           = 3'b101
) (
  input logic            i_clk,
  input logic            i_rst,
  conv_encoder_if.slave  bus
);
  localparam int CW = $clog2(SIZE_DATA_IN + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE_DATA_IN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, ENCODE, TAIL, DONE} state_t;

  state_t                  state;
  logic [SIZE_DATA_IN-1:0] msg;
  logic                    s1, s2;
  logic [CW-1:0]           cnt;
  logic                    u;
  logic [2:0]              taps;

  // Tail bits are forced to zero to flush the shift register back to 00.
  always_comb begin
    u    = (state == ENCODE) ? msg[SIZE_DATA_IN-1] : 1'b0;
    taps = {u, s1, s2};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      msg          <= '0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      cnt          <= '0;
      bus.o_ready  <= 1'b1;
      bus.o_valid  <= 1'b0;
      bus.o_symbol <= 2'b00;
      bus.o_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.o_valid  <= 1'b0;
          bus.o_symbol <= 2'b00;
          bus.o_done   <= 1'b0;
          if (bus.i_start) begin
            msg         <= bus.i_data;
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            bus.o_ready <= 1'b0;
            state       <= ENCODE;
          end
        end
        ENCODE, TAIL: begin
          bus.o_symbol <= {^(G0 & taps), ^(G1 & taps)};
          bus.o_valid  <= 1'b1;
          s1           <= u;
          s2           <= s1;
          if (state == ENCODE) begin
            msg <= msg << 1;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= TAIL;
            end else begin
              cnt <= cnt + ONE;
            end
          end else if (cnt == ONE) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DONE: begin
          // First DONE cycle still shows the last tail symbol; o_done follows it.
          bus.o_valid  <= 1'b0;
          bus.o_symbol <= 2'b00;
          if (!bus.o_done) begin
            bus.o_done <= 1'b1;
          end else begin
            bus.o_done  <= 1'b0;
            bus.o_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
